// File: rtl/oled_string_streamer_pkg.sv
// Shared definitions for the OLED string streamer: FSM state encoding, ASCII
// constants and the active levels of the oledControl handshake.
package oled_string_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    REQ,
    NEXT,
    GAP
  } oled_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  // Both sendDataValid and sendDone are active-high levels of a four-phase handshake.
  localparam logic REQ_ASSERT = 1'b1;
  localparam logic ACK_ASSERT = 1'b1;

endpackage

// File: rtl/oled_string_streamer_if.sv
// Byte handshake between the string streamer (master) and oledControl (slave).
interface oled_string_streamer_if;

  logic [7:0] sendData;
  logic       sendDataValid;
  logic       sendDone;

  modport master (output sendData, output sendDataValid, input sendDone);
  modport slave  (input sendData, input sendDataValid, output sendDone);

endinterface

// File: rtl/oled_string_streamer_refresh_timer.sv
// Refresh interval counter: counts enabled cycles and pulses expire (registered)
// once REFRESH_CYCLES enabled cycles have elapsed since the last clear.
module oled_refresh_timer #(
  parameter int unsigned REFRESH_CYCLES = 10_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] count;

  // Count wraps to zero on expiry so it can never run past REFRESH_CYCLES-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (enable) begin
      if (count == LAST) begin
        count  <= '0;
        expire <= 1'b1;
      end else begin
        count  <= count + CW'(1);
        expire <= 1'b0;
      end
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/oled_string_streamer.sv
// Latches a packed ASCII string and streams it byte-by-byte to oledControl, with
// optional auto-refresh. Define OLED_STREAM_NUL_TO_SPACE_EN to send NUL bytes as spaces.
module oled_string_streamer
  import oled_string_streamer_pkg::*;
#(
  parameter int unsigned STR_BYTES      = 64,
  parameter bit          MSB_FIRST      = 1'b1,
  parameter int unsigned REFRESH_CYCLES = 10_000_000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           auto_refresh,
  input  logic [8*STR_BYTES-1:0]         str_in,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(STR_BYTES+1)-1:0] byte_idx,
  oled_string_streamer_if.master         oled
);

  localparam int unsigned IW = $clog2(STR_BYTES + 1);
  localparam int unsigned SW = (STR_BYTES > 1) ? $clog2(STR_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(STR_BYTES);

  oled_state_t                 state;
  logic [STR_BYTES-1:0][7:0]   str_q;
  logic [SW-1:0]               sel;
  logic [7:0]                  tx_byte;
  logic                        refresh_due;
  logic                        restart;
  logic                        timer_clear;
  logic                        timer_en;

  assign timer_clear = (state == NEXT) && (byte_idx == LAST_IDX);
  assign timer_en    = (state == GAP) && auto_refresh;
  assign restart     = start || (refresh_due && auto_refresh);

  oled_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (refresh_due)
  );

  always_comb begin
    if (MSB_FIRST) sel = SW'(STR_BYTES - 1) - SW'(byte_idx);
    else           sel = SW'(byte_idx);
    tx_byte = str_q[sel];
`ifdef OLED_STREAM_NUL_TO_SPACE_EN
    if (tx_byte == ASCII_NUL) tx_byte = ASCII_SPACE;
`endif
  end

  // A new byte is only offered once oledControl has released sendDone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      byte_idx           <= '0;
      str_q              <= '0;
      oled.sendData      <= ASCII_NUL;
      oled.sendDataValid <= ~REQ_ASSERT;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, GAP: begin
          if (restart) begin
            str_q    <= str_in;
            byte_idx <= '0;
            busy     <= 1'b1;
            state    <= WAIT_LOW;
          end else if (state == GAP && !auto_refresh) begin
            state <= IDLE;
          end
        end
        WAIT_LOW: begin
          if (oled.sendDone != ACK_ASSERT) begin
            oled.sendData      <= tx_byte;
            oled.sendDataValid <= REQ_ASSERT;
            state              <= REQ;
          end
        end
        REQ: begin
          if (oled.sendDone == ACK_ASSERT) begin
            oled.sendDataValid <= ~REQ_ASSERT;
            if (byte_idx != LAST_IDX) byte_idx <= byte_idx + IW'(1);
            state <= NEXT;
          end
        end
        NEXT: begin
          if (byte_idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= GAP;
          end else begin
            state <= WAIT_LOW;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_string_streamer.sv
// Bench for oled_string_streamer: MSB-first and LSB-first instances share stimulus,
// each checked every cycle against a timeline model of the handshake.
module tb_oled_string_streamer;

  localparam int NB = 4;
  localparam int RC = 10;
  localparam int IW = $clog2(NB + 1);

`ifdef OLED_STREAM_NUL_TO_SPACE_EN
  localparam logic [31:0] NUL_MSB = 32'h41202020;
  localparam logic [31:0] NUL_LSB = 32'h20202041;
`else
  localparam logic [31:0] NUL_MSB = 32'h41000000;
  localparam logic [31:0] NUL_LSB = 32'h00000041;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          auto_refresh;
  logic [8*NB-1:0] str_in;
  logic          hold_done;
  logic          rand_ack;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam bit MSB = (k == 0);

    oled_string_streamer_if bus ();
    logic          busy;
    logic          done;
    logic [IW-1:0] byte_idx;

    oled_string_streamer #(
      .STR_BYTES      (NB),
      .MSB_FIRST      (MSB),
      .REFRESH_CYCLES (RC)
    ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .auto_refresh (auto_refresh),
      .str_in       (str_in),
      .busy         (busy),
      .done         (done),
      .byte_idx     (byte_idx),
      .oled         (bus)
    );

    // oledControl stand-in: acks after a delay, releases only once valid drops.
    int ack_wait, rel_wait;
    always @(negedge clock) begin
      if (!reset) begin
        bus.sendDone = 1'b0;
        ack_wait = 0;
        rel_wait = 0;
      end else if (hold_done) begin
        bus.sendDone = 1'b1;
      end else if (!bus.sendDone) begin
        if (bus.sendDataValid) begin
          if (ack_wait == 0) begin
            bus.sendDone = 1'b1;
            rel_wait = rand_ack ? $urandom_range(0, 2) : 1;
          end else begin
            ack_wait--;
          end
        end else begin
          ack_wait = rand_ack ? $urandom_range(0, 3) : 2;
        end
      end else if (!bus.sendDataValid) begin
        if (rel_wait == 0) bus.sendDone = 1'b0;
        else rel_wait--;
      end
    end

    // Timeline model: edge numbers at which valid may rise, the pass ends, and a refresh fires.
    logic       m_busy, m_done, m_valid, take;
    logic [7:0] m_data;
    logic [7:0] m_bytes [NB];
    int         m_count, m_e, raise_at, finish_at, gap_start, idx;
    bit         in_gap, auto_ok;
    always @(posedge clock or negedge reset) begin
      if (!reset) begin
        m_busy = 0; m_done = 0; m_valid = 0; m_data = 8'h00; m_count = 0; m_e = 0;
        raise_at = 0; finish_at = -1; gap_start = 0; in_gap = 0; auto_ok = 0;
      end else begin
        m_e++;
        m_done = 0;
        if (m_busy) begin
          if (m_valid) begin
            if (bus.sendDone) begin
              m_valid = 0;
              m_count++;
              if (m_count == NB) finish_at = m_e + 1;
              else raise_at = m_e + 2;
            end
          end else if (m_count < NB && m_e >= raise_at && !bus.sendDone) begin
            m_valid = 1;
            m_data  = m_bytes[m_count];
          end else if (m_e == finish_at) begin
            m_busy = 0; m_done = 1; in_gap = 1; auto_ok = 1; gap_start = m_e;
          end
        end else begin
          take = start;
          if (in_gap) begin
            auto_ok = auto_ok && auto_refresh;
            if (auto_ok && m_e == gap_start + RC + 1) take = 1;
          end
          if (take) begin
            for (int j = 0; j < NB; j++) begin
              idx = MSB ? NB - 1 - j : j;
              m_bytes[j] = str_in[8*idx +: 8];
`ifdef OLED_STREAM_NUL_TO_SPACE_EN
              if (m_bytes[j] == 8'h00) m_bytes[j] = 8'h20;
`endif
            end
            m_busy = 1; m_count = 0; raise_at = m_e + 1; finish_at = -1; in_gap = 0;
          end
        end
      end
    end

    logic       prev_valid = 1'b0;
    logic [7:0] log_q [$];
    int         cyc = 0, done_cyc = -1, gap_cyc = -1, done_cnt = 0;
    always @(negedge clock) begin
      cyc++;
      check_output($sformatf("busy%0d", k), busy, m_busy);
      check_output($sformatf("done%0d", k), done, m_done);
      check_output($sformatf("byte_idx%0d", k), byte_idx, m_count);
      check_output($sformatf("valid%0d", k), bus.sendDataValid, m_valid);
      if (m_valid) check_output($sformatf("sendData%0d", k), bus.sendData, m_data);
      if (bus.sendDataValid && !prev_valid) begin
        log_q.push_back(bus.sendData);
        if (done_cyc >= 0 && gap_cyc < 0) gap_cyc = cyc - done_cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        gap_cyc  = -1;
      end
      prev_valid = bus.sendDataValid;
    end
  end

  function automatic logic [31:0] pack4(input logic [7:0] q[$], input int base);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = {r[23:0], (base + i < q.size()) ? q[base+i] : 8'hEE};
    return r;
  endfunction

  task automatic check_log(input string name, input int b0, input int b1,
                           input logic [31:0] e0, input logic [31:0] e1);
    check_output({name, "_len0"}, g[0].log_q.size() - b0, 4);
    check_output({name, "_len1"}, g[1].log_q.size() - b1, 4);
    check_output({name, "_bytes0"}, pack4(g[0].log_q, b0), e0);
    check_output({name, "_bytes1"}, pack4(g[1].log_q, b1), e1);
  endtask

  task automatic check_reset_values(input string name);
    check_output({name, "_valid0"}, g[0].bus.sendDataValid, 0);
    check_output({name, "_valid1"}, g[1].bus.sendDataValid, 0);
    check_output({name, "_data0"}, g[0].bus.sendData, 0);
    check_output({name, "_busy0"}, g[0].busy, 0);
    check_output({name, "_busy1"}, g[1].busy, 0);
    check_output({name, "_idx0"}, g[0].byte_idx, 0);
    check_output({name, "_idx1"}, g[1].byte_idx, 0);
    check_output({name, "_done0"}, g[0].done, 0);
  endtask

  task automatic wait_done(input int want0, input int want1, input int budget);
    int n = 0;
    while ((g[0].done_cnt < want0 || g[1].done_cnt < want1) && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check_output("wait_done_timeout", (n >= budget), 0);
  endtask

  task automatic apply_stimulus(input logic [8*NB-1:0] s);
    str_in = s;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
  endtask

  initial begin
    int b0, b1, d0, d1, n;
    reset = 1'b0; start = 1'b0; auto_refresh = 1'b0; str_in = '0;
    hold_done = 1'b0; rand_ack = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single pass, both byte orders.
    b0 = g[0].log_q.size(); b1 = g[1].log_q.size(); d0 = g[0].done_cnt; d1 = g[1].done_cnt;
    apply_stimulus("ABCD");
    wait_done(d0 + 1, d1 + 1, 300);
    check_log("order", b0, b1, 32'h41424344, 32'h44434241);
    check_output("pass_idx0", g[0].byte_idx, 4);
    check_output("pass_busy0", g[0].busy, 0);
    check_output("pass_dones0", g[0].done_cnt - d0, 1);

    // Restart and string change while busy are ignored.
    b0 = g[0].log_q.size(); b1 = g[1].log_q.size(); d0 = g[0].done_cnt; d1 = g[1].done_cnt;
    apply_stimulus("ABCD");
    repeat (4) @(negedge clock);
    apply_stimulus("WXYZ");
    wait_done(d0 + 1, d1 + 1, 300);
    repeat (30) @(negedge clock);
    check_log("busy_start", b0, b1, 32'h41424344, 32'h44434241);
    check_output("busy_start_dones0", g[0].done_cnt - d0, 1);
    check_output("busy_start_dones1", g[1].done_cnt - d1, 1);

    // Auto-refresh interval, then drop auto_refresh mid-pass.
    d0 = g[0].done_cnt; d1 = g[1].done_cnt;
    auto_refresh = 1'b1;
    apply_stimulus("ABCD");
    wait_done(d0 + 1, d1 + 1, 300);
    n = 0;
    while (g[0].gap_cyc < 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check_output("refresh_gap", g[0].gap_cyc, RC + 2);
    auto_refresh = 1'b0;
    wait_done(d0 + 2, d1 + 2, 300);
    repeat (30) @(negedge clock);
    check_output("refresh_stop0", g[0].done_cnt - d0, 2);
    check_output("refresh_stop1", g[1].done_cnt - d1, 2);

    // sendDone stuck high at start: no request until it drops, no duplicate byte.
    b0 = g[0].log_q.size(); b1 = g[1].log_q.size(); d0 = g[0].done_cnt; d1 = g[1].done_cnt;
    hold_done = 1'b1;
    repeat (2) @(negedge clock);
    apply_stimulus("ABCD");
    repeat (6) @(negedge clock);
    check_output("held_valid0", g[0].bus.sendDataValid, 0);
    check_output("held_valid1", g[1].bus.sendDataValid, 0);
    hold_done = 1'b0;
    wait_done(d0 + 1, d1 + 1, 300);
    check_log("held", b0, b1, 32'h41424344, 32'h44434241);

    // Asynchronous reset in the middle of the second byte, then a NUL-padded string.
    apply_stimulus({8'h41, 8'h00, 8'h00, 8'h00});
    n = 0;
    while (!(g[0].byte_idx == 1 && g[0].bus.sendDataValid) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_output("reach_byte2", (n >= 100), 0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check_reset_values("mid_reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    b0 = g[0].log_q.size(); b1 = g[1].log_q.size(); d0 = g[0].done_cnt; d1 = g[1].done_cnt;
    apply_stimulus({8'h41, 8'h00, 8'h00, 8'h00});
    wait_done(d0 + 1, d1 + 1, 300);
    check_log("nul", b0, b1, NUL_MSB, NUL_LSB);

    // Randomised traffic checked by the per-cycle model.
    rand_ack = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        str_in = $urandom;
        if ($urandom_range(0, 1) == 1) str_in[15:8] = 8'h00;
      end
      if ($urandom_range(0, 63) == 0) auto_refresh = ~auto_refresh;
    end
    start = 1'b0;
    auto_refresh = 1'b0;
    n = 0;
    while ((g[0].busy || g[1].busy) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_output("drain_timeout", (n >= 300), 0);
    repeat (5) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
